// File: rtl/OmpSsManager.sv
// OmpSs Manager shared definitions: command/ack codes, command word field
// positions, and the lock client state encoding.
package OmpSsManager;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h05;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h02;

  localparam int unsigned CMD_TYPE_L   = 0;
  localparam int unsigned CMD_TYPE_H   = 7;
  localparam int unsigned LOCK_ID_L    = 32;
  localparam int unsigned LOCK_ID_H    = 39;
  localparam int unsigned LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND_LOCK,
    WAIT_ACK,
    BACKOFF,
    HELD,
    SEND_UNLOCK
  } lock_client_state_t;

  // Builds a command word: all zero except the command code and lock id fields.
  function automatic logic [63:0] lock_cmd_word(input logic [7:0]              code,
                                                input logic [LOCK_ID_BITS-1:0] id);
    logic [63:0] w;
    w = '0;
    w[CMD_TYPE_H:CMD_TYPE_L] = code;
    w[LOCK_ID_H:LOCK_ID_L]   = id;
    return w;
  endfunction

endpackage

// File: rtl/lock_client.sv
// lock_client: accelerator-side initiator for the OmpSs Manager lock protocol.
// Turns a level acquire/release handshake into CMD_LOCK / CMD_UNLOCK words,
// consumes the ack, retries after RETRY_DELAY idle cycles on reject, and
// holds the grant until released.
//
// Ports:
//   clk, rstn          clock; synchronous active-low reset
//   lock_req           level acquire request; lock_id_in latched leaving IDLE
//   lock_grant         high while the lock is held
//   unlock_req         level release request, honoured only while held
//   unlock_done        one-cycle pulse on the unlock command handshake
//   outStream_*        command stream to the manager (TLAST=1, TID=ACC_ID)
//   inStream_*         ack stream from the manager, code in TDATA[7:0]
//   reject_count       (LOCK_CLIENT_STATS_EN) saturating count of non-OK acks
//   lock_count         (LOCK_CLIENT_STATS_EN) saturating count of acquisitions
//
// Optional feature macro: LOCK_CLIENT_STATS_EN.
module lock_client
  import OmpSsManager::*;
#(
  parameter int unsigned MAX_ACCS    = 16,
  parameter int unsigned ACC_ID      = 0,
  parameter int unsigned RETRY_DELAY = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         lock_req,
  input  logic [LOCK_ID_BITS-1:0]      lock_id_in,
  output logic                         lock_grant,
  input  logic                         unlock_req,
  output logic                         unlock_done,
  output logic [63:0]                  outStream_TDATA,
  output logic                         outStream_TVALID,
  input  logic                         outStream_TREADY,
  output logic                         outStream_TLAST,
  output logic [$clog2(MAX_ACCS)-1:0]  outStream_TID,
  input  logic [63:0]                  inStream_TDATA,
  input  logic                         inStream_TVALID,
`ifdef LOCK_CLIENT_STATS_EN
  output logic [31:0]                  reject_count,
  output logic [31:0]                  lock_count,
`endif
  output logic                         inStream_TREADY
);

  localparam int unsigned ACC_BITS      = $clog2(MAX_ACCS);
  localparam logic [15:0] RETRY_DELAY_V = 16'(RETRY_DELAY);

  lock_client_state_t      r_state, w_next;
  logic [15:0]             r_count, w_count_next;
  logic [LOCK_ID_BITS-1:0] r_lock_id;
  logic                    w_ack_hs;
  logic                    w_ack_ok;
  logic                    w_unused_ack_bits;

  assign w_ack_hs          = inStream_TVALID & inStream_TREADY;
  assign w_ack_ok          = (inStream_TDATA[7:0] == ACK_OK_CODE);
  assign w_unused_ack_bits = ^inStream_TDATA[63:8];
  assign outStream_TLAST   = 1'b1;
  assign outStream_TID     = ACC_BITS'(ACC_ID);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_lock_id <= '0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
      if (r_state == IDLE && lock_req) r_lock_id <= lock_id_in;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_count_next     = r_count;
    lock_grant       = 1'b0;
    unlock_done      = 1'b0;
    outStream_TVALID = 1'b0;
    outStream_TDATA  = '0;
    inStream_TREADY  = 1'b0;
    case (r_state)
      IDLE: begin
        if (lock_req) w_next = SEND_LOCK;
      end
      SEND_LOCK: begin
        outStream_TVALID = 1'b1;
        outStream_TDATA  = lock_cmd_word(CMD_LOCK_CODE, r_lock_id);
        if (outStream_TREADY) w_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        inStream_TREADY = 1'b1;
        if (inStream_TVALID) begin
          if (w_ack_ok) begin
            w_next = HELD;
          end else if (RETRY_DELAY_V == '0) begin
            w_next = SEND_LOCK;
          end else begin
            w_next       = BACKOFF;
            w_count_next = RETRY_DELAY_V;
          end
        end
      end
      BACKOFF: begin
        // BACKOFF spans exactly RETRY_DELAY cycles (count RETRY_DELAY..1), so the
        // resend is RETRY_DELAY+1 cycles after the reject; a zero delay bypasses it.
        if (!lock_req) begin
          w_next       = IDLE;
          w_count_next = '0;
        end else if (r_count <= 16'd1) begin
          w_next       = SEND_LOCK;
          w_count_next = '0;
        end else begin
          w_count_next = r_count - 16'd1;
        end
      end
      HELD: begin
        lock_grant = 1'b1;
        if (unlock_req) w_next = SEND_UNLOCK;
      end
      SEND_UNLOCK: begin
        outStream_TVALID = 1'b1;
        outStream_TDATA  = lock_cmd_word(CMD_UNLOCK_CODE, r_lock_id);
        if (outStream_TREADY) begin
          unlock_done = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef LOCK_CLIENT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      reject_count <= '0;
      lock_count   <= '0;
    end else if (w_ack_hs) begin
      if (w_ack_ok) begin
        if (lock_count != '1) lock_count <= lock_count + 32'd1;
      end else begin
        if (reject_count != '1) reject_count <= reject_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lock_client.sv
// Directed self-checking bench for lock_client. Command words are predicted
// into a queue when a request is driven and compared on each handshake.
module tb_lock_client;
  import OmpSsManager::*;

  localparam int unsigned RD = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, lock_req, unlock_req, lock_grant, unlock_done;
  logic [7:0]  lock_id_in;
  logic [63:0] out_tdata, in_tdata;
  logic        out_tvalid, out_tready, out_tlast, in_tvalid, in_tready;
  logic [3:0]  out_tid;

  logic        b_lock_req, b_unlock_req, b_lock_grant, b_unlock_done;
  logic [63:0] b_out_tdata, b_in_tdata;
  logic        b_out_tvalid, b_out_tready, b_out_tlast, b_in_tvalid, b_in_tready;
  logic [3:0]  b_out_tid;

`ifdef LOCK_CLIENT_STATS_EN
  logic [31:0] reject_count, lock_count, b_rej, b_lk;
`endif

  lock_client #(.MAX_ACCS(16), .ACC_ID(3), .RETRY_DELAY(RD)) u_dut (
    .clk(clk), .rstn(rstn), .lock_req(lock_req), .lock_id_in(lock_id_in),
    .lock_grant(lock_grant), .unlock_req(unlock_req), .unlock_done(unlock_done),
    .outStream_TDATA(out_tdata), .outStream_TVALID(out_tvalid),
    .outStream_TREADY(out_tready), .outStream_TLAST(out_tlast),
    .outStream_TID(out_tid), .inStream_TDATA(in_tdata),
    .inStream_TVALID(in_tvalid),
`ifdef LOCK_CLIENT_STATS_EN
    .reject_count(reject_count), .lock_count(lock_count),
`endif
    .inStream_TREADY(in_tready)
  );

  lock_client #(.MAX_ACCS(16), .ACC_ID(1), .RETRY_DELAY(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .lock_req(b_lock_req), .lock_id_in(8'd1),
    .lock_grant(b_lock_grant), .unlock_req(b_unlock_req), .unlock_done(b_unlock_done),
    .outStream_TDATA(b_out_tdata), .outStream_TVALID(b_out_tvalid),
    .outStream_TREADY(b_out_tready), .outStream_TLAST(b_out_tlast),
    .outStream_TID(b_out_tid), .inStream_TDATA(b_in_tdata),
    .inStream_TVALID(b_in_tvalid),
`ifdef LOCK_CLIENT_STATS_EN
    .reject_count(b_rej), .lock_count(b_lk),
`endif
    .inStream_TREADY(b_in_tready)
  );

  logic [63:0] exp_q[$];
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned out_hs = 0, unlock_pulses = 0, grant_cycles = 0;
  int unsigned exp_rej = 0, exp_lock = 0;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [63:0] prev_d = '0;

  function automatic logic [63:0] cmd(input logic [7:0] code, input logic [7:0] id);
    return {24'd0, id, 24'd0, code};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input logic [7:0] code);
    int unsigned n = 0;
    in_tvalid = 1'b1;
    in_tdata  = {56'd0, code};
    while (!in_tready && n < 50) begin
      step();
      n++;
    end
    check("ack_accept", in_tready, 1);
    check("grant_in_ack_cycle", lock_grant, 0);
    step();
    in_tvalid = 1'b0;
    in_tdata  = '0;
    if (code == ACK_OK_CODE) exp_lock++;
    else exp_rej++;
  endtask

  task automatic count_to_valid(output int unsigned n);
    n = 0;
    while (!out_tvalid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic check_stats();
`ifdef LOCK_CLIENT_STATS_EN
    check("reject_count", reject_count, exp_rej);
    check("lock_count", lock_count, exp_lock);
`endif
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn && out_tvalid && out_tready) begin
      out_hs++;
      check("cmd_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("cmd_word", out_tdata, exp_q.pop_front());
        check("cmd_tid", out_tid, 3);
        check("cmd_tlast", out_tlast, 1);
      end
    end
    if (rstn && prev_v && !prev_r) begin
      check("stall_valid", out_tvalid, 1);
      check("stall_data", out_tdata, prev_d);
    end
    prev_v = rstn && out_tvalid;
    prev_r = out_tready;
    prev_d = out_tdata;
    if (rstn && unlock_done) unlock_pulses++;
    if (lock_grant) grant_cycles++;
  end

  initial begin
    int unsigned n, hs0, up0, g0;
    rstn = 1'b0; lock_req = 1'b0; unlock_req = 1'b0; lock_id_in = '0;
    out_tready = 1'b1; in_tvalid = 1'b0; in_tdata = '0;
    b_lock_req = 1'b0; b_unlock_req = 1'b0; b_out_tready = 1'b1;
    b_in_tvalid = 1'b0; b_in_tdata = '0;
    step(); step();
    check("rst_grant", lock_grant, 0);
    check("rst_tvalid", out_tvalid, 0);
    check("rst_tdata", out_tdata, 0);
    check("rst_in_tready", in_tready, 0);
    check("rst_unlock_done", unlock_done, 0);
    check("tid_const", out_tid, 3);
    check_stats();
    rstn = 1'b1;

    // 1: basic acquire / release
    lock_id_in = 8'd5; lock_req = 1'b1;
    exp_q.push_back(cmd(CMD_LOCK_CODE, 8'd5));
    step();
    check("t1_valid_latency", out_tvalid, 1);
    check("t1_lock_word", out_tdata, cmd(CMD_LOCK_CODE, 8'd5));
    step();
    check("t1_wait_in_tready", in_tready, 1);
    check("t1_valid_dropped", out_tvalid, 0);
    step(); step();
    do_ack(ACK_OK_CODE);
    check("t1_grant", lock_grant, 1);
    lock_req = 1'b0;
    step(); step(); step();
    check("t1_grant_held", lock_grant, 1);
    unlock_req = 1'b1;
    exp_q.push_back(cmd(CMD_UNLOCK_CODE, 8'd5));
    step();
    check("t1_grant_drop", lock_grant, 0);
    check("t1_unlock_valid", out_tvalid, 1);
    check("t1_unlock_done", unlock_done, 1);
    unlock_req = 1'b0;
    step();
    check("t1_done_pulse", unlock_done, 0);
    check("t1_idle_valid", out_tvalid, 0);
    check("t1_pulses", unlock_pulses, 1);

    // 2: reject, reject, ok with RETRY_DELAY=4
    lock_id_in = 8'd9; lock_req = 1'b1;
    repeat (3) exp_q.push_back(cmd(CMD_LOCK_CODE, 8'd9));
    step(); step();
    do_ack(ACK_REJECT_CODE);
    count_to_valid(n);
    check("t2_resend1_gap", n, RD);
    step();
    do_ack(ACK_REJECT_CODE);
    count_to_valid(n);
    check("t2_resend2_gap", n, RD);
    step();
    do_ack(ACK_OK_CODE);
    check("t2_grant", lock_grant, 1);
    check_stats();
    lock_req = 1'b0; unlock_req = 1'b1;
    exp_q.push_back(cmd(CMD_UNLOCK_CODE, 8'd9));
    step(); step();
    unlock_req = 1'b0;

    // 3: backpressure on both commands
    out_tready = 1'b0; lock_id_in = 8'd7; lock_req = 1'b1;
    exp_q.push_back(cmd(CMD_LOCK_CODE, 8'd7));
    step();
    lock_req = 1'b0;
    hs0 = out_hs;
    repeat (7) step();
    check("t3_lock_no_xfer", out_hs, hs0);
    out_tready = 1'b1;
    step();
    check("t3_lock_one_xfer", out_hs, hs0 + 1);
    do_ack(ACK_OK_CODE);
    check("t3_grant", lock_grant, 1);
    out_tready = 1'b0; unlock_req = 1'b1;
    exp_q.push_back(cmd(CMD_UNLOCK_CODE, 8'd7));
    step();
    unlock_req = 1'b0;
    hs0 = out_hs;
    up0 = unlock_pulses;
    repeat (7) step();
    check("t3_unlock_stalled", unlock_done, 0);
    out_tready = 1'b1;
    #1;
    check("t3_unlock_done", unlock_done, 1);
    step();
    check("t3_unlock_one_xfer", out_hs, hs0 + 1);
    check("t3_unlock_pulses", unlock_pulses, up0 + 1);

    // 4: abort during backoff
    g0 = grant_cycles;
    lock_id_in = 8'd2; lock_req = 1'b1;
    exp_q.push_back(cmd(CMD_LOCK_CODE, 8'd2));
    step(); step();
    do_ack(ACK_REJECT_CODE);
    step();
    lock_req = 1'b0;
    hs0 = out_hs;
    step();
    repeat (10) begin
      check("t4_idle_no_valid", out_tvalid, 0);
      step();
    end
    check("t4_no_resend", out_hs, hs0);
    check("t4_no_grant", grant_cycles, g0);
    check_stats();

    // 5: stray ack in IDLE; RETRY_DELAY=0 instance resends next cycle
    in_tvalid = 1'b1; in_tdata = {56'd0, ACK_OK_CODE};
    #1;
    check("t5_stray_tready", in_tready, 0);
    step(); step();
    check("t5_stray_tready_held", in_tready, 0);
    check("t5_stray_no_grant", lock_grant, 0);
    in_tvalid = 1'b0; in_tdata = '0;
    b_lock_req = 1'b1;
    step(); step();
    b_in_tvalid = 1'b1; b_in_tdata = {56'd0, ACK_REJECT_CODE};
    check("t5_b_in_tready", b_in_tready, 1);
    step();
    b_in_tvalid = 1'b0; b_in_tdata = '0;
    check("t5_rd0_resend", b_out_tvalid, 1);
    b_lock_req = 1'b0;

    // 6: reset while HELD, then while stalled in SEND_LOCK
    lock_id_in = 8'd4; lock_req = 1'b1;
    exp_q.push_back(cmd(CMD_LOCK_CODE, 8'd4));
    step(); step();
    do_ack(ACK_OK_CODE);
    check("t6_grant", lock_grant, 1);
    lock_req = 1'b0; rstn = 1'b0;
    up0 = unlock_pulses;
    hs0 = out_hs;
    step();
    rstn = 1'b1;
    exp_rej = 0; exp_lock = 0;
    check("t6_rst_grant", lock_grant, 0);
    check("t6_rst_valid", out_tvalid, 0);
    check("t6_rst_tdata", out_tdata, 0);
    check("t6_rst_in_tready", in_tready, 0);
    check_stats();
    out_tready = 1'b0; lock_id_in = 8'd6; lock_req = 1'b1;
    step();
    check("t6_send_valid", out_tvalid, 1);
    rstn = 1'b0; lock_req = 1'b0;
    step();
    rstn = 1'b1;
    check("t6_rst2_valid", out_tvalid, 0);
    check("t6_rst2_tdata", out_tdata, 0);
    check("t6_rst2_unlock_done", unlock_done, 0);
    out_tready = 1'b1;
    repeat (4) step();
    check("t6_no_cmd_after_rst", out_hs, hs0);
    check("t6_no_unlock", unlock_pulses, up0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
